// File: rtl/fifo_pkg.sv
// Shared helpers and default sizes for the dual-clock FIFO: Gray/binary
// pointer conversions used on both sides of the clock-domain crossing.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 8;
    localparam int ADDRSIZE_DEF   = 4;

    // Callers zero-extend into the 32-bit argument and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at
// or above its position.
module fifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_rd_cntrl.sv
// Read-side controller of the dual-clock FIFO: read pointer, registered empty
// flag and a one-entry output register. Define FIFO_RD_LEVEL_EN for r_LEVEL.
module fifo_rd_cntrl
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int ADDRSIZE   = ADDRSIZE_DEF
) (
    input  logic                  rCLK,
    input  logic                  rRST,
    input  logic [ADDRSIZE-1:0]   rq2_wptr,
    input  logic [FIFO_WIDTH-1:0] r_DATA,
    output logic [ADDRSIZE-1:0]   r_ADDR,
    output logic [ADDRSIZE-1:0]   r_PTR,
    output logic                  r_EMPTY,
    output logic [FIFO_WIDTH-1:0] out_DATA,
    output logic                  out_VALID,
    input  logic                  out_READY
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDRSIZE-1:0]   r_LEVEL
`endif
);

    logic [ADDRSIZE-1:0] rbin;
    logic [ADDRSIZE-1:0] rbin_next;
    logic [ADDRSIZE-1:0] rgray_next;
    logic                fetch;
    logic                out_valid_next;

    // Handshake: a word moves to the consumer on any edge where out_VALID and
    // out_READY are both high; out_READY with out_VALID low has no effect.
    // The output register refills in the same edge it is emptied, so a
    // non-empty memory sustains one word per cycle.
    assign fetch          = !r_EMPTY && (!out_VALID || out_READY);
    assign out_valid_next = fetch || (out_VALID && !out_READY);
    assign rbin_next      = rbin + {{(ADDRSIZE-1){1'b0}}, fetch};
    assign rgray_next     = ADDRSIZE'(bin2gray(32'(rbin_next)));
    assign r_ADDR         = {1'b0, rbin[ADDRSIZE-2:0]};

    always_ff @(posedge rCLK or posedge rRST) begin
        if (rRST) begin
            rbin    <= '0;
            r_PTR   <= '0;
            r_EMPTY <= 1'b1;
        end else begin
            rbin    <= rbin_next;
            r_PTR   <= rgray_next;
            r_EMPTY <= (rgray_next == rq2_wptr);
        end
    end

    // r_DATA is the combinational memory word at r_ADDR, captured on fetch.
    always_ff @(posedge rCLK or posedge rRST) begin
        if (rRST) begin
            out_DATA  <= '0;
            out_VALID <= 1'b0;
        end else begin
            out_VALID <= out_valid_next;
            if (fetch) begin
                out_DATA <= r_DATA;
            end
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [ADDRSIZE-1:0] wbin;
    logic [ADDRSIZE-1:0] level_next;

    fifo_gray2bin #(.W(ADDRSIZE)) u_gray2bin (
        .gray (rq2_wptr),
        .bin  (wbin)
    );

    // Words still in memory plus the one held in the output register.
    assign level_next = (wbin - rbin_next) + {{(ADDRSIZE-1){1'b0}}, out_valid_next};

    always_ff @(posedge rCLK or posedge rRST) begin
        if (rRST) begin
            r_LEVEL <= '0;
        end else begin
            r_LEVEL <= level_next;
        end
    end
`endif

endmodule
